// File: rtl/axi_rd_arbiter_2to1.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter_2to1
// Shares one AXI read slave (AR + R channels) between two read masters M0/M1.
// Round-robin arbitration, one burst in flight. The grant is held from the AR
// handshake until the R LAST handshake. R beats go to the granted master only.
//
// Optional feature macro: RD_TIMEOUT_EN
//   Defined   : R-beat watchdog (TIMEOUT_CYC) forces an error LAST beat
//               (RESP=2'b10) to the granted master when the slave stalls.
//   Undefined : no watchdog; a burst waits for the slave indefinitely.
//
// Ports
//   BUS_CLK, BUS_RST          clock, asynchronous active-high reset
//   Mn_RD_ADDR_*  (n=0,1)     AR channel from master n (ID/ADDR/LEN/BURST/VALID in, READY out)
//   Mn_RD_BACK_ID, Mn_RD_DATA*  R channel to master n (ID/DATA/RESP/LAST/VALID out, READY in)
//   SLAVE_RD_ADDR_*           AR channel to the slave
//   SLAVE_RD_BACK_ID, SLAVE_RD_DATA*  R channel from the slave
//   RD_GRANT                  one-hot current grant, 2'b00 when idle
//   RD_BUSY                   high whenever a burst is being arbitrated/served
// ----------------------------------------------------------------------------
module axi_rd_arbiter_2to1
`ifdef RD_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYC = 1024
)
`endif
(
   input  logic        BUS_CLK,
   input  logic        BUS_RST,
   input  logic [3:0]  M0_RD_ADDR_ID,
   input  logic [31:0] M0_RD_ADDR,
   input  logic [7:0]  M0_RD_ADDR_LEN,
   input  logic [1:0]  M0_RD_ADDR_BURST,
   input  logic        M0_RD_ADDR_VALID,
   output logic        M0_RD_ADDR_READY,
   output logic [3:0]  M0_RD_BACK_ID,
   output logic [31:0] M0_RD_DATA,
   output logic [1:0]  M0_RD_DATA_RESP,
   output logic        M0_RD_DATA_LAST,
   output logic        M0_RD_DATA_VALID,
   input  logic        M0_RD_DATA_READY,
   input  logic [3:0]  M1_RD_ADDR_ID,
   input  logic [31:0] M1_RD_ADDR,
   input  logic [7:0]  M1_RD_ADDR_LEN,
   input  logic [1:0]  M1_RD_ADDR_BURST,
   input  logic        M1_RD_ADDR_VALID,
   output logic        M1_RD_ADDR_READY,
   output logic [3:0]  M1_RD_BACK_ID,
   output logic [31:0] M1_RD_DATA,
   output logic [1:0]  M1_RD_DATA_RESP,
   output logic        M1_RD_DATA_LAST,
   output logic        M1_RD_DATA_VALID,
   input  logic        M1_RD_DATA_READY,
   output logic [3:0]  SLAVE_RD_ADDR_ID,
   output logic [31:0] SLAVE_RD_ADDR,
   output logic [7:0]  SLAVE_RD_ADDR_LEN,
   output logic [1:0]  SLAVE_RD_ADDR_BURST,
   output logic        SLAVE_RD_ADDR_VALID,
   input  logic        SLAVE_RD_ADDR_READY,
   input  logic [3:0]  SLAVE_RD_BACK_ID,
   input  logic [31:0] SLAVE_RD_DATA,
   input  logic [1:0]  SLAVE_RD_DATA_RESP,
   input  logic        SLAVE_RD_DATA_LAST,
   input  logic        SLAVE_RD_DATA_VALID,
   output logic        SLAVE_RD_DATA_READY,
   output logic [1:0]  RD_GRANT,
   output logic        RD_BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10
`ifdef RD_TIMEOUT_EN
      , ERR = 2'b11
`endif
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] grant, grant_nxt;
   logic [1:0] last_grant, last_grant_nxt;
   logic [1:0] pick;
   logic       r_hs;

   assign r_hs     = SLAVE_RD_DATA_VALID & SLAVE_RD_DATA_READY;
   assign RD_GRANT = grant;
   assign RD_BUSY  = (state != IDLE);

`ifdef RD_TIMEOUT_EN
   // id_lat is only consumed by the synthesized error beat.
   logic [3:0]  id_lat, id_lat_nxt;
   logic [15:0] wd_cnt;
   logic [15:0] wd_inc;

   assign wd_inc = wd_cnt + 16'd1;

   // Watchdog: restarts on DATA entry and on every R handshake, counts while in DATA.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         wd_cnt <= 16'd0;
      end else if (state == DATA && !r_hs) begin
         wd_cnt <= wd_inc;
      end else begin
         wd_cnt <= 16'd0;
      end
   end
`endif

   // State, grant and arbitration-history registers.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_grant <= 2'b10;   // M1 as last winner: M0 takes the first tie
`ifdef RD_TIMEOUT_EN
         id_lat     <= 4'd0;
`endif
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
`ifdef RD_TIMEOUT_EN
         id_lat     <= id_lat_nxt;
`endif
      end
   end

   // Next-state logic and round-robin arbitration.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      pick           = 2'b00;
`ifdef RD_TIMEOUT_EN
      id_lat_nxt     = id_lat;
`endif
      case (state)
         IDLE: begin
            if (M0_RD_ADDR_VALID && M1_RD_ADDR_VALID) begin
               pick = (last_grant == 2'b01) ? 2'b10 : 2'b01;
            end else if (M0_RD_ADDR_VALID) begin
               pick = 2'b01;
            end else if (M1_RD_ADDR_VALID) begin
               pick = 2'b10;
            end else begin
               pick = 2'b00;
            end
            if (pick != 2'b00) begin
               state_nxt      = ADDR;
               grant_nxt      = pick;
               last_grant_nxt = pick;
`ifdef RD_TIMEOUT_EN
               id_lat_nxt     = pick[1] ? M1_RD_ADDR_ID : M0_RD_ADDR_ID;
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         ADDR: begin
            if (SLAVE_RD_ADDR_READY) begin
               state_nxt = DATA;
            end else begin
               state_nxt = ADDR;
            end
         end
         DATA: begin
            if (r_hs && SLAVE_RD_DATA_LAST) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
`ifdef RD_TIMEOUT_EN
            end else if (!r_hs && wd_inc == 16'(TIMEOUT_CYC - 1)) begin
               state_nxt = ERR;
`endif
            end else begin
               state_nxt = DATA;
            end
         end
`ifdef RD_TIMEOUT_EN
         ERR: begin
            if ((grant[0] && M0_RD_DATA_READY) || (grant[1] && M1_RD_DATA_READY)) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
            end else begin
               state_nxt = ERR;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   // Channel muxing: AR forwarded in ADDR, R passed through in DATA, all else quiet.
   always_comb begin
      M0_RD_ADDR_READY    = 1'b0;
      M1_RD_ADDR_READY    = 1'b0;
      SLAVE_RD_ADDR_ID    = 4'd0;
      SLAVE_RD_ADDR       = 32'd0;
      SLAVE_RD_ADDR_LEN   = 8'd0;
      SLAVE_RD_ADDR_BURST = 2'b00;
      SLAVE_RD_ADDR_VALID = 1'b0;
      M0_RD_BACK_ID       = 4'd0;
      M0_RD_DATA          = 32'd0;
      M0_RD_DATA_RESP     = 2'b00;
      M0_RD_DATA_LAST     = 1'b0;
      M0_RD_DATA_VALID    = 1'b0;
      M1_RD_BACK_ID       = 4'd0;
      M1_RD_DATA          = 32'd0;
      M1_RD_DATA_RESP     = 2'b00;
      M1_RD_DATA_LAST     = 1'b0;
      M1_RD_DATA_VALID    = 1'b0;
      SLAVE_RD_DATA_READY = 1'b0;
      case (state)
         IDLE: begin
`ifdef RD_TIMEOUT_EN
            SLAVE_RD_DATA_READY = 1'b1;   // sink late beats from a timed-out burst
`else
            SLAVE_RD_DATA_READY = 1'b0;
`endif
         end
         ADDR: begin
            SLAVE_RD_ADDR_VALID = 1'b1;
            if (grant[0]) begin
               SLAVE_RD_ADDR_ID    = M0_RD_ADDR_ID;
               SLAVE_RD_ADDR       = M0_RD_ADDR;
               SLAVE_RD_ADDR_LEN   = M0_RD_ADDR_LEN;
               SLAVE_RD_ADDR_BURST = M0_RD_ADDR_BURST;
               M0_RD_ADDR_READY    = SLAVE_RD_ADDR_READY;
            end else begin
               SLAVE_RD_ADDR_ID    = M1_RD_ADDR_ID;
               SLAVE_RD_ADDR       = M1_RD_ADDR;
               SLAVE_RD_ADDR_LEN   = M1_RD_ADDR_LEN;
               SLAVE_RD_ADDR_BURST = M1_RD_ADDR_BURST;
               M1_RD_ADDR_READY    = SLAVE_RD_ADDR_READY;
            end
         end
         DATA: begin
            if (grant[0]) begin
               M0_RD_BACK_ID       = SLAVE_RD_BACK_ID;
               M0_RD_DATA          = SLAVE_RD_DATA;
               M0_RD_DATA_RESP     = SLAVE_RD_DATA_RESP;
               M0_RD_DATA_LAST     = SLAVE_RD_DATA_LAST;
               M0_RD_DATA_VALID    = SLAVE_RD_DATA_VALID;
               SLAVE_RD_DATA_READY = M0_RD_DATA_READY;
            end else begin
               M1_RD_BACK_ID       = SLAVE_RD_BACK_ID;
               M1_RD_DATA          = SLAVE_RD_DATA;
               M1_RD_DATA_RESP     = SLAVE_RD_DATA_RESP;
               M1_RD_DATA_LAST     = SLAVE_RD_DATA_LAST;
               M1_RD_DATA_VALID    = SLAVE_RD_DATA_VALID;
               SLAVE_RD_DATA_READY = M1_RD_DATA_READY;
            end
         end
`ifdef RD_TIMEOUT_EN
         ERR: begin
            SLAVE_RD_DATA_READY = 1'b1;
            if (grant[0]) begin
               M0_RD_BACK_ID    = id_lat;
               M0_RD_DATA_RESP  = 2'b10;
               M0_RD_DATA_LAST  = 1'b1;
               M0_RD_DATA_VALID = 1'b1;
            end else begin
               M1_RD_BACK_ID    = id_lat;
               M1_RD_DATA_RESP  = 2'b10;
               M1_RD_DATA_LAST  = 1'b1;
               M1_RD_DATA_VALID = 1'b1;
            end
         end
`endif
         default: begin
            SLAVE_RD_DATA_READY = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Directed bench for axi_rd_arbiter_2to1 (default build, no watchdog).
// Inputs are driven just after the falling edge; outputs are checked 1 time
// unit later, well away from the rising edge.
module tb_axi_rd_arbiter_2to1;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST = 1'b1;
   logic [3:0]  M0_RD_ADDR_ID, M1_RD_ADDR_ID;
   logic [31:0] M0_RD_ADDR, M1_RD_ADDR;
   logic [7:0]  M0_RD_ADDR_LEN, M1_RD_ADDR_LEN;
   logic [1:0]  M0_RD_ADDR_BURST, M1_RD_ADDR_BURST;
   logic        M0_RD_ADDR_VALID, M1_RD_ADDR_VALID;
   logic        M0_RD_ADDR_READY, M1_RD_ADDR_READY;
   logic [3:0]  M0_RD_BACK_ID, M1_RD_BACK_ID;
   logic [31:0] M0_RD_DATA, M1_RD_DATA;
   logic [1:0]  M0_RD_DATA_RESP, M1_RD_DATA_RESP;
   logic        M0_RD_DATA_LAST, M1_RD_DATA_LAST;
   logic        M0_RD_DATA_VALID, M1_RD_DATA_VALID;
   logic        M0_RD_DATA_READY, M1_RD_DATA_READY;
   logic [3:0]  SLAVE_RD_ADDR_ID;
   logic [31:0] SLAVE_RD_ADDR;
   logic [7:0]  SLAVE_RD_ADDR_LEN;
   logic [1:0]  SLAVE_RD_ADDR_BURST;
   logic        SLAVE_RD_ADDR_VALID, SLAVE_RD_ADDR_READY;
   logic [3:0]  SLAVE_RD_BACK_ID;
   logic [31:0] SLAVE_RD_DATA;
   logic [1:0]  SLAVE_RD_DATA_RESP;
   logic        SLAVE_RD_DATA_LAST, SLAVE_RD_DATA_VALID, SLAVE_RD_DATA_READY;
   logic [1:0]  RD_GRANT;
   logic        RD_BUSY;

   int checks = 0;
   int errors = 0;

   axi_rd_arbiter_2to1 dut (
      .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
      .M0_RD_ADDR_ID(M0_RD_ADDR_ID), .M0_RD_ADDR(M0_RD_ADDR), .M0_RD_ADDR_LEN(M0_RD_ADDR_LEN),
      .M0_RD_ADDR_BURST(M0_RD_ADDR_BURST), .M0_RD_ADDR_VALID(M0_RD_ADDR_VALID), .M0_RD_ADDR_READY(M0_RD_ADDR_READY),
      .M0_RD_BACK_ID(M0_RD_BACK_ID), .M0_RD_DATA(M0_RD_DATA), .M0_RD_DATA_RESP(M0_RD_DATA_RESP),
      .M0_RD_DATA_LAST(M0_RD_DATA_LAST), .M0_RD_DATA_VALID(M0_RD_DATA_VALID), .M0_RD_DATA_READY(M0_RD_DATA_READY),
      .M1_RD_ADDR_ID(M1_RD_ADDR_ID), .M1_RD_ADDR(M1_RD_ADDR), .M1_RD_ADDR_LEN(M1_RD_ADDR_LEN),
      .M1_RD_ADDR_BURST(M1_RD_ADDR_BURST), .M1_RD_ADDR_VALID(M1_RD_ADDR_VALID), .M1_RD_ADDR_READY(M1_RD_ADDR_READY),
      .M1_RD_BACK_ID(M1_RD_BACK_ID), .M1_RD_DATA(M1_RD_DATA), .M1_RD_DATA_RESP(M1_RD_DATA_RESP),
      .M1_RD_DATA_LAST(M1_RD_DATA_LAST), .M1_RD_DATA_VALID(M1_RD_DATA_VALID), .M1_RD_DATA_READY(M1_RD_DATA_READY),
      .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID), .SLAVE_RD_ADDR(SLAVE_RD_ADDR), .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN),
      .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST), .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID),
      .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY),
      .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID), .SLAVE_RD_DATA(SLAVE_RD_DATA), .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP),
      .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST), .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID),
      .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY),
      .RD_GRANT(RD_GRANT), .RD_BUSY(RD_BUSY)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge BUS_CLK);
   endtask

   task automatic clr();
      M0_RD_ADDR_ID = 4'd0; M0_RD_ADDR = 32'd0; M0_RD_ADDR_LEN = 8'd0; M0_RD_ADDR_BURST = 2'b00;
      M0_RD_ADDR_VALID = 1'b0; M0_RD_DATA_READY = 1'b0;
      M1_RD_ADDR_ID = 4'd0; M1_RD_ADDR = 32'd0; M1_RD_ADDR_LEN = 8'd0; M1_RD_ADDR_BURST = 2'b00;
      M1_RD_ADDR_VALID = 1'b0; M1_RD_DATA_READY = 1'b0;
      SLAVE_RD_ADDR_READY = 1'b0;
      SLAVE_RD_BACK_ID = 4'd0; SLAVE_RD_DATA = 32'd0; SLAVE_RD_DATA_RESP = 2'b00;
      SLAVE_RD_DATA_LAST = 1'b0; SLAVE_RD_DATA_VALID = 1'b0;
   endtask

   task automatic ar0(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
      M0_RD_ADDR_ID = id; M0_RD_ADDR = a; M0_RD_ADDR_LEN = len; M0_RD_ADDR_VALID = 1'b1;
   endtask

   task automatic ar1(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
      M1_RD_ADDR_ID = id; M1_RD_ADDR = a; M1_RD_ADDR_LEN = len; M1_RD_ADDR_VALID = 1'b1;
   endtask

   task automatic rbeat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
      SLAVE_RD_BACK_ID = id; SLAVE_RD_DATA = d; SLAVE_RD_DATA_RESP = resp;
      SLAVE_RD_DATA_LAST = last; SLAVE_RD_DATA_VALID = 1'b1;
   endtask

   task automatic r_idle();
      SLAVE_RD_DATA_VALID = 1'b0; SLAVE_RD_DATA_LAST = 1'b0;
   endtask

   initial begin
      int k;
      bit rp [7];
      rp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // ---------------- reset state ----------------
      clr();
      cyc(); #1;
      chk("rst_grant", RD_GRANT, 2'b00);
      chk("rst_busy", RD_BUSY, 1'b0);
      chk("rst_arv", SLAVE_RD_ADDR_VALID, 1'b0);
      chk("rst_rready", SLAVE_RD_DATA_READY, 1'b0);
      chk("rst_m0_rv", M0_RD_DATA_VALID, 1'b0);
      chk("rst_m1_rv", M1_RD_DATA_VALID, 1'b0);
      cyc(); BUS_RST = 1'b0;

      // ---------------- tie after reset: M0 first, then M1 ----------------
      cyc(); ar0(4'd1, 32'h100, 8'd0); ar1(4'd5, 32'h200, 8'd0); #1;
      chk("tie_idle_grant", RD_GRANT, 2'b00);
      chk("tie_idle_arv", SLAVE_RD_ADDR_VALID, 1'b0);
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("tie_grant_m0", RD_GRANT, 2'b01);
      chk("tie_addr_m0", SLAVE_RD_ADDR, 32'h100);
      chk("tie_id_m0", SLAVE_RD_ADDR_ID, 4'd1);
      chk("tie_m0_aready", M0_RD_ADDR_READY, 1'b1);
      chk("tie_m1_aready", M1_RD_ADDR_READY, 1'b0);
      cyc(); M0_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M0_RD_DATA_READY = 1'b1;
      rbeat(4'd1, 32'h11, 2'b00, 1'b1); #1;
      chk("tie_m0_rv", M0_RD_DATA_VALID, 1'b1);
      chk("tie_m0_data", M0_RD_DATA, 32'h11);
      chk("tie_m0_last", M0_RD_DATA_LAST, 1'b1);
      chk("tie_m1_rv", M1_RD_DATA_VALID, 1'b0);
      chk("tie_m1_wait_aready", M1_RD_ADDR_READY, 1'b0);
      chk("tie_m1_wait_arv", SLAVE_RD_ADDR_VALID, 1'b0);
      cyc(); r_idle(); M0_RD_DATA_READY = 1'b0; #1;
      chk("tie_gap_busy", RD_BUSY, 1'b0);
      chk("tie_gap_grant", RD_GRANT, 2'b00);
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("tie_grant_m1", RD_GRANT, 2'b10);
      chk("tie_addr_m1", SLAVE_RD_ADDR, 32'h200);
      chk("tie_id_m1", SLAVE_RD_ADDR_ID, 4'd5);
      chk("tie_m1_aready2", M1_RD_ADDR_READY, 1'b1);
      chk("tie_m0_aready2", M0_RD_ADDR_READY, 1'b0);
      cyc(); M1_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M1_RD_DATA_READY = 1'b1;
      rbeat(4'd5, 32'h22, 2'b00, 1'b1); #1;
      chk("tie_m1_rv2", M1_RD_DATA_VALID, 1'b1);
      chk("tie_m1_data", M1_RD_DATA, 32'h22);
      chk("tie_m1_id", M1_RD_BACK_ID, 4'd5);
      chk("tie_m0_rv2", M0_RD_DATA_VALID, 1'b0);
      chk("tie_m1_rready", SLAVE_RD_DATA_READY, 1'b1);
      // Repeat tie: M1 was last winner, so M0 wins again.
      cyc(); r_idle(); M1_RD_DATA_READY = 1'b0; ar0(4'd3, 32'h300, 8'd0); ar1(4'd6, 32'h400, 8'd0); #1;
      chk("tie2_idle_busy", RD_BUSY, 1'b0);
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("tie2_grant", RD_GRANT, 2'b01);
      chk("tie2_addr", SLAVE_RD_ADDR, 32'h300);
      cyc(); clr(); M0_RD_DATA_READY = 1'b1; rbeat(4'd3, 32'h33, 2'b00, 1'b1); #1;
      chk("tie2_m0_rv", M0_RD_DATA_VALID, 1'b1);
      cyc(); clr(); #1;
      chk("tie2_done_busy", RD_BUSY, 1'b0);

      // ---------------- M0 addr 0x10 LEN=3 ID=2 ----------------
      cyc(); ar0(4'd2, 32'h10, 8'd3); M0_RD_ADDR_BURST = 2'b01; #1;
      chk("b1_idle_grant", RD_GRANT, 2'b00);
      chk("b1_idle_arv", SLAVE_RD_ADDR_VALID, 1'b0);
      chk("b1_idle_aready", M0_RD_ADDR_READY, 1'b0);
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("b1_arv", SLAVE_RD_ADDR_VALID, 1'b1);
      chk("b1_addr", SLAVE_RD_ADDR, 32'h10);
      chk("b1_len", SLAVE_RD_ADDR_LEN, 8'd3);
      chk("b1_id", SLAVE_RD_ADDR_ID, 4'd2);
      chk("b1_burst", SLAVE_RD_ADDR_BURST, 2'b01);
      chk("b1_aready", M0_RD_ADDR_READY, 1'b1);
      chk("b1_grant", RD_GRANT, 2'b01);
      chk("b1_busy", RD_BUSY, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (i == 0) begin
            M0_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M0_RD_DATA_READY = 1'b1;
         end
         rbeat(4'd2, 32'hA0 + i, (i == 1) ? 2'b01 : 2'b00, (i == 3)); #1;
         chk("b1_rv", M0_RD_DATA_VALID, 1'b1);
         chk("b1_data", M0_RD_DATA, 32'hA0 + i);
         chk("b1_rid", M0_RD_BACK_ID, 4'd2);
         chk("b1_resp", M0_RD_DATA_RESP, (i == 1) ? 2'b01 : 2'b00);
         chk("b1_last", M0_RD_DATA_LAST, (i == 3) ? 1'b1 : 1'b0);
         chk("b1_m1_rv", M1_RD_DATA_VALID, 1'b0);
         chk("b1_m1_data", M1_RD_DATA, 32'd0);
         chk("b1_rready", SLAVE_RD_DATA_READY, 1'b1);
      end
      cyc(); clr(); #1;
      chk("b1_end_grant", RD_GRANT, 2'b00);
      chk("b1_end_busy", RD_BUSY, 1'b0);
      chk("b1_end_rv", M0_RD_DATA_VALID, 1'b0);

      // ---------------- M0 RREADY low for 3 cycles mid-burst ----------------
      cyc(); ar0(4'd4, 32'h500, 8'd3); #1;
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("bp_arv", SLAVE_RD_ADDR_VALID, 1'b1);
      k = 0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         if (i == 0) begin
            M0_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0;
         end
         M0_RD_DATA_READY = rp[i];
         rbeat(4'd4, 32'hB0 + k, 2'b00, (k == 3)); #1;
         chk("bp_rready", SLAVE_RD_DATA_READY, rp[i]);
         chk("bp_data", M0_RD_DATA, 32'hB0 + k);
         chk("bp_busy", RD_BUSY, 1'b1);
         if (rp[i]) k++;
      end
      cyc(); clr(); #1;
      chk("bp_end_busy", RD_BUSY, 1'b0);

      // ---------------- M1 LEN=0 then immediate M0 LEN=1 ----------------
      cyc(); ar1(4'd7, 32'h600, 8'd0); #1;
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("l0_grant", RD_GRANT, 2'b10);
      cyc(); M1_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M1_RD_DATA_READY = 1'b1;
      rbeat(4'd7, 32'hC0, 2'b00, 1'b1); ar0(4'd8, 32'h700, 8'd1); #1;
      chk("l0_m1_rv", M1_RD_DATA_VALID, 1'b1);
      chk("l0_m1_last", M1_RD_DATA_LAST, 1'b1);
      chk("l0_m0_aready", M0_RD_ADDR_READY, 1'b0);
      chk("l0_arv_data", SLAVE_RD_ADDR_VALID, 1'b0);
      cyc(); r_idle(); M1_RD_DATA_READY = 1'b0; #1;
      chk("l0_gap_arv", SLAVE_RD_ADDR_VALID, 1'b0);
      chk("l0_gap_busy", RD_BUSY, 1'b0);
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("l0_m0_arv", SLAVE_RD_ADDR_VALID, 1'b1);
      chk("l0_m0_addr", SLAVE_RD_ADDR, 32'h700);
      chk("l0_m0_aready2", M0_RD_ADDR_READY, 1'b1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         if (i == 0) begin
            M0_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M0_RD_DATA_READY = 1'b1;
         end
         rbeat(4'd8, 32'hD0 + i, 2'b00, (i == 1)); #1;
         chk("l1_data", M0_RD_DATA, 32'hD0 + i);
         chk("l1_last", M0_RD_DATA_LAST, (i == 1) ? 1'b1 : 1'b0);
      end
      cyc(); clr(); #1;
      chk("l1_end_busy", RD_BUSY, 1'b0);

      // ---------------- async reset at beat 2 of 4 ----------------
      cyc(); ar0(4'd9, 32'h800, 8'd3); #1;
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         if (i == 0) begin
            M0_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M0_RD_DATA_READY = 1'b1;
         end
         rbeat(4'd9, 32'hE0 + i, 2'b00, 1'b0); #1;
         chk("ra_rv", M0_RD_DATA_VALID, 1'b1);
      end
      cyc(); rbeat(4'd9, 32'hE2, 2'b00, 1'b0); #1;
      chk("ra_pre_rv", M0_RD_DATA_VALID, 1'b1);
      BUS_RST = 1'b1; #1;
      chk("ra_rv_zero", M0_RD_DATA_VALID, 1'b0);
      chk("ra_grant_zero", RD_GRANT, 2'b00);
      chk("ra_busy_zero", RD_BUSY, 1'b0);
      chk("ra_rready_zero", SLAVE_RD_DATA_READY, 1'b0);
      chk("ra_arv_zero", SLAVE_RD_ADDR_VALID, 1'b0);
      cyc(); clr(); BUS_RST = 1'b0; #1;
      chk("ra_rel_busy", RD_BUSY, 1'b0);
      cyc(); ar1(4'd10, 32'h900, 8'd1); #1;
      cyc(); SLAVE_RD_ADDR_READY = 1'b1; #1;
      chk("ra_m1_addr", SLAVE_RD_ADDR, 32'h900);
      chk("ra_m1_grant", RD_GRANT, 2'b10);
      for (int i = 0; i < 2; i++) begin
         cyc();
         if (i == 0) begin
            M1_RD_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_READY = 1'b0; M1_RD_DATA_READY = 1'b1;
         end
         rbeat(4'd10, 32'hF0 + i, 2'b00, (i == 1)); #1;
         chk("ra_m1_data", M1_RD_DATA, 32'hF0 + i);
         chk("ra_m1_last", M1_RD_DATA_LAST, (i == 1) ? 1'b1 : 1'b0);
      end
      cyc(); clr(); #1;
      chk("ra_end_busy", RD_BUSY, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
